// File: rtl/rr_arb_pkg.sv
// Shared defaults and width helpers for the round robin arbiter and its requester front end.
package rr_arb_pkg;
    localparam int DEF_CLIENTS        = 8;
    localparam int DEF_DEPTH          = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int wait_w(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

    // Pending-count type for the default configuration.
    typedef logic [$clog2(DEF_DEPTH + 1)-1:0] cnt_t;
endpackage

// File: rtl/rr_req_slot.sv
// One client's pending counter, request decode and push_ready; optional starvation
// watchdog built only when RR_REQ_TIMEOUT_EN is defined.
module rr_req_slot
    import rr_arb_pkg::*;
#(
    parameter int DEPTH          = DEF_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int CNT_W         = cnt_w(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             grant,
    output logic             request,
    output logic             push_ready,
    output logic [CNT_W-1:0] cnt,
    output logic             timeout
);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic             acc;
    logic             con;

    // Both outputs decode registers only, so push/grant never reach request combinationally.
    assign request    = (cnt_q != '0);
    assign push_ready = (cnt_q < CNT_FULL);
    assign acc        = push && push_ready;
    assign con        = grant && request;
    assign cnt        = cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (acc && !con) begin
            cnt_q <= cnt_q + CNT_ONE;
        end else if (!acc && con) begin
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

`ifdef RR_REQ_TIMEOUT_EN
    localparam int               WAIT_W   = wait_w(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    logic [WAIT_W-1:0] wait_q;
    logic              timeout_q;

    // Counts cycles of unserved request; the flag is raised on the step that reaches saturation.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else if (!request || con) begin
            wait_q <= '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_q <= wait_q + WAIT_ONE;
            if (wait_q == WAIT_MAX - WAIT_ONE) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif
endmodule

// File: rtl/rr_arb_requester.sv
// Client-side request queue for the round robin arbiter with sticky protocol-error flags.
// Optional starvation watchdog enabled by defining RR_REQ_TIMEOUT_EN.
module rr_arb_requester
    import rr_arb_pkg::*;
#(
    parameter int CLIENTS        = DEF_CLIENTS,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int CNT_W         = cnt_w(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CLIENTS-1:0]       push,
    output logic [CLIENTS-1:0]       push_ready,
    output logic [CLIENTS-1:0]       request,
    input  logic [CLIENTS-1:0]       grant,
    output logic [CLIENTS*CNT_W-1:0] pending,
    output logic                     overflow_err,
    output logic                     grant_err,
    output logic [CLIENTS-1:0]       timeout
);
    logic overflow_q;
    logic grant_err_q;

    for (genvar i = 0; i < CLIENTS; i++) begin : g_slot
        rr_req_slot #(
            .DEPTH          (DEPTH),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_slot (
            .clock      (clock),
            .reset      (reset),
            .push       (push[i]),
            .grant      (grant[i]),
            .request    (request[i]),
            .push_ready (push_ready[i]),
            .cnt        (pending[i*CNT_W +: CNT_W]),
            .timeout    (timeout[i])
        );
    end

    // A grant to an idle client and a multi-hot grant are both arbiter faults.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            grant_err_q <= 1'b0;
        end else begin
            if (|(push & ~push_ready)) begin
                overflow_q <= 1'b1;
            end
            if ((|(grant & ~request)) || !$onehot0(grant)) begin
                grant_err_q <= 1'b1;
            end
        end
    end

    assign overflow_err = overflow_q;
    assign grant_err    = grant_err_q;
endmodule

// File: tb/tb_rr_arb_requester.sv
// Directed plus randomized bench for rr_arb_requester with a reference model feeding a scoreboard.
module tb_rr_arb_requester;
    localparam int CLIENTS = 8;
    localparam int DEPTH   = 4;
    localparam int TO      = 8;
    localparam int CNT_W   = $clog2(DEPTH + 1);
`ifdef RR_REQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                     clock = 1'b0;
    logic                     reset;
    logic [CLIENTS-1:0]       push;
    logic [CLIENTS-1:0]       grant;
    logic [CLIENTS-1:0]       push_ready;
    logic [CLIENTS-1:0]       request;
    logic [CLIENTS*CNT_W-1:0] pending;
    logic                     overflow_err;
    logic                     grant_err;
    logic [CLIENTS-1:0]       timeout;

    rr_arb_requester #(
        .CLIENTS        (CLIENTS),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .push         (push),
        .push_ready   (push_ready),
        .request      (request),
        .grant        (grant),
        .pending      (pending),
        .overflow_err (overflow_err),
        .grant_err    (grant_err),
        .timeout      (timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [CLIENTS-1:0]       request;
        logic [CLIENTS-1:0]       push_ready;
        logic [CLIENTS-1:0]       timeout;
        logic [CLIENTS*CNT_W-1:0] pending;
        logic                     ovf;
        logic                     gerr;
    } exp_t;

    exp_t               sb[$];
    int                 mcnt[CLIENTS];
    int                 mwait[CLIENTS];
    logic               movf;
    logic               mgerr;
    logic [CLIENTS-1:0] mto;
    int                 checks = 0;
    int                 errors = 0;
    string              cur_tag = "init";

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed %0h expected %0h", cur_tag, tag, obs, exp);
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        int   c;
        for (int i = 0; i < CLIENTS; i++) begin
            c = mcnt[i];
            e.request[i]    = (c != 0);
            e.push_ready[i] = (c < DEPTH);
            e.pending[i*CNT_W +: CNT_W] = c[CNT_W-1:0];
        end
        e.timeout = TO_EN ? mto : '0;
        e.ovf     = movf;
        e.gerr    = mgerr;
        return e;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s/scoreboard: observed empty queue expected one entry", cur_tag);
        end else begin
            e = sb.pop_front();
            chk("request",      64'(request),      64'(e.request));
            chk("pending",      64'(pending),      64'(e.pending));
            chk("push_ready",   64'(push_ready),   64'(e.push_ready));
            chk("overflow_err", 64'(overflow_err), 64'(e.ovf));
            chk("grant_err",    64'(grant_err),    64'(e.gerr));
            chk("timeout",      64'(timeout),      64'(e.timeout));
        end
    endtask

    // Drive one cycle of stimulus, advance the model, then compare after the edge.
    task automatic step(input logic rst, input logic [CLIENTS-1:0] p, input logic [CLIENTS-1:0] g);
        reset = rst;
        push  = p;
        grant = g;
        if (rst) begin
            for (int i = 0; i < CLIENTS; i++) begin
                mcnt[i]  = 0;
                mwait[i] = 0;
            end
            movf  = 1'b0;
            mgerr = 1'b0;
            mto   = '0;
        end else begin
            if ($countones(g) > 1) mgerr = 1'b1;
            for (int i = 0; i < CLIENTS; i++) begin
                bit acc;
                bit con;
                acc = p[i] && (mcnt[i] < DEPTH);
                con = g[i] && (mcnt[i] > 0);
                if (p[i] && mcnt[i] == DEPTH) movf = 1'b1;
                if (g[i] && mcnt[i] == 0) mgerr = 1'b1;
                if (mcnt[i] != 0 && !con) begin
                    if (mwait[i] < TO) mwait[i]++;
                    if (mwait[i] == TO) mto[i] = 1'b1;
                end else begin
                    mwait[i] = 0;
                end
                if (acc && !con) mcnt[i]++;
                else if (!acc && con) mcnt[i]--;
            end
        end
        sb.push_back(snapshot());
        @(posedge clock);
        #1;
        check_out();
    endtask

    initial begin
        logic [CLIENTS-1:0] rp;
        logic [CLIENTS-1:0] rg;
        int                 k;

        reset = 1'b1;
        push  = '0;
        grant = '0;
        cur_tag = "reset";
        step(1'b1, '0, '0);
        step(1'b1, '0, '0);
        chk("push_ready_all", 64'(push_ready), 64'hFF);

        cur_tag = "single";
        step(1'b0, 8'h04, 8'h00);
        chk("request_04", 64'(request), 64'h04);
        chk("pending2", 64'(pending[2*CNT_W +: CNT_W]), 64'd1);
        step(1'b0, 8'h00, 8'h04);
        chk("request_cleared", 64'(request), 64'h00);

        cur_tag = "overflow";
        for (int i = 0; i < 5; i++) step(1'b0, 8'h01, 8'h00);
        chk("cnt0_full", 64'(pending[0 +: CNT_W]), 64'd4);
        chk("ovf_set", 64'(overflow_err), 64'd1);
        step(1'b0, 8'h01, 8'h01);
        chk("full_grant_dec", 64'(pending[0 +: CNT_W]), 64'd3);

        cur_tag = "push_and_grant";
        step(1'b0, 8'h20, 8'h00);
        step(1'b0, 8'h20, 8'h00);
        step(1'b0, 8'h20, 8'h20);
        chk("cnt5_held", 64'(pending[5*CNT_W +: CNT_W]), 64'd2);

        cur_tag = "grant_idle";
        step(1'b1, '0, '0);
        step(1'b0, 8'h03, 8'h00);
        step(1'b0, 8'h00, 8'h10);
        chk("gerr_idle", 64'(grant_err), 64'd1);
        cur_tag = "grant_multi";
        step(1'b1, '0, '0);
        step(1'b0, 8'h03, 8'h00);
        step(1'b0, 8'h00, 8'h03);
        chk("gerr_multi", 64'(grant_err), 64'd1);
        chk("both_dec", 64'(request), 64'h00);

        cur_tag = "timeout";
        step(1'b1, '0, '0);
        step(1'b0, 8'h02, 8'h00);
        for (int i = 0; i < TO - 1; i++) step(1'b0, 8'h00, 8'h00);
        chk("timeout_early", 64'(timeout), 64'h00);
        step(1'b0, 8'h00, 8'h00);
        chk("timeout_hit", 64'(timeout), TO_EN ? 64'h02 : 64'h00);
        step(1'b0, 8'h00, 8'h02);
        step(1'b0, 8'h00, 8'h00);

        cur_tag = "reset_mid";
        step(1'b0, 8'h89, 8'h00);
        step(1'b0, 8'h89, 8'h00);
        step(1'b1, 8'h00, 8'h00);
        chk("rst_request", 64'(request), 64'h00);
        chk("rst_pending", 64'(pending), 64'h0);

        cur_tag = "random";
        for (int n = 0; n < 400; n++) begin
            rp = CLIENTS'($urandom);
            rg = '0;
            k  = int'($urandom_range(0, 9));
            if (k < 6) begin
                int c = int'($urandom_range(0, CLIENTS - 1));
                if (mcnt[c] != 0) rg[c] = 1'b1;
            end else if (k == 9) begin
                rg = CLIENTS'($urandom);
            end
            step($urandom_range(0, 63) == 0, rp, rg);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
